// File: rtl/mem_port_sched_pkg.sv
// Shared types for the fetch/data RAM port scheduler: FSM states, access sizes, grant encoding.
package mem_port_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SECOND = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    localparam logic [2:0] SZ_B = 3'b001;
    localparam logic [2:0] SZ_H = 3'b010;
    localparam logic [2:0] SZ_W = 3'b100;

    // Anything that is not a byte or a half is handled as a full word.
    function automatic logic [2:0] size_bytes(input logic [2:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_lane.sv
// Byte-lane datapath: store masks/shifts for both word cycles and load alignment with extension.
module mem_port_lane
    import mem_port_sched_pkg::*;
(
    input  logic [1:0]  a,
    input  logic [2:0]  size,
    input  logic        se,
    input  logic [31:0] wdata,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic        split,
    output logic [3:0]  mask0,
    output logic [3:0]  mask1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] rdata
);

    logic [2:0]  n;
    logic [7:0]  bmask;
    logic [63:0] wide_w;
    logic [31:0] raw;

    always_comb begin
        n      = size_bytes(size);
        split  = ({1'b0, a} + n) > 3'd4;
        // Byte enables across the two-word window; upper nibble spills into word1.
        bmask  = ((8'd1 << n) - 8'd1) << a;
        mask0  = bmask[3:0];
        mask1  = bmask[7:4];
        wide_w = {32'd0, wdata} << {a, 3'b000};
        wdata0 = wide_w[31:0];
        wdata1 = wide_w[63:32];
        raw    = 32'({word1, word0} >> {a, 3'b000});
        case (size)
            SZ_B:    rdata = {{24{se & raw[7]}}, raw[7:0]};
            SZ_H:    rdata = {{16{se & raw[15]}}, raw[15:0]};
            default: rdata = raw;
        endcase
    end

endmodule

// File: rtl/mem_port_sched.sv
// Shares one single-port sync-read RAM between instruction fetch and data ports.
// MEM_PORT_SCHED_MISALIGN_EN: misaligned data accesses become two word cycles; otherwise they flag d_err.
module mem_port_sched
    import mem_port_sched_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ready,
    output logic [15:0]       i_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_size,
    input  logic              d_se,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_wmask,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

`ifdef MEM_PORT_SCHED_MISALIGN_EN
    localparam bit MISALIGN = 1'b1;
`else
    localparam bit MISALIGN = 1'b0;
`endif

    state_t            state;
    grant_t            grant;
    grant_t            last_grant;
    grant_t            pick;
    logic [31:0]       lo_buf;
    logic [ADDR_W-1:0] i_word;
    logic [ADDR_W-1:0] d_word0;
    logic [ADDR_W-1:0] d_word1;
    logic              split;
    logic [3:0]        mask0;
    logic [3:0]        mask1;
    logic [31:0]       wdata0;
    logic [31:0]       wdata1;
    logic [31:0]       ld_word0;
    logic [31:0]       ld_rdata;
    logic              unused_bits;

    assign i_word      = i_addr[ADDR_W+1:2];
    assign d_word0     = d_addr[ADDR_W+1:2];
    assign d_word1     = d_word0 + ADDR_W'(1);
    assign ld_word0    = (split && MISALIGN) ? lo_buf : ram_rdata;
    assign unused_bits = ^{i_addr[0], i_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

    mem_port_lane u_lane (
        .a      (d_addr[1:0]),
        .size   (d_size),
        .se     (d_se),
        .wdata  (d_wdata),
        .word0  (ld_word0),
        .word1  (ram_rdata),
        .split  (split),
        .mask0  (mask0),
        .mask1  (mask1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .rdata  (ld_rdata)
    );

    // Round-robin only matters when both ports ask in the same IDLE cycle.
    always_comb begin
        if (i_req && d_req)
            pick = (last_grant == GNT_DATA) ? GNT_FETCH : GNT_DATA;
        else if (d_req)
            pick = GNT_DATA;
        else
            pick = GNT_FETCH;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= GNT_FETCH;
            last_grant <= GNT_FETCH;
            lo_buf     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        grant      <= pick;
                        last_grant <= pick;
                        state      <= (pick == GNT_DATA && split && MISALIGN) ? SECOND : RESP;
                    end
                end
                SECOND: begin
                    lo_buf <= ram_rdata;
                    state  <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request fields are held by the requester until ready, so later cycles reuse them live.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wmask = 4'd0;
        ram_wdata = 32'd0;
        i_ready   = 1'b0;
        i_data    = 16'd0;
        d_ready   = 1'b0;
        d_rdata   = 32'd0;
        d_err     = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        if (pick == GNT_FETCH) begin
                            ram_en   = 1'b1;
                            ram_addr = i_word;
                        end else if (!split || MISALIGN) begin
                            ram_en   = 1'b1;
                            ram_addr = d_word0;
                            if (d_we) begin
                                ram_we    = 1'b1;
                                ram_wmask = mask0;
                                ram_wdata = wdata0;
                            end
                        end
                    end
                end
                SECOND: begin
                    ram_en   = 1'b1;
                    ram_addr = d_word1;
                    if (d_we) begin
                        ram_we    = 1'b1;
                        ram_wmask = mask1;
                        ram_wdata = wdata1;
                    end
                end
                RESP: begin
                    if (grant == GNT_FETCH) begin
                        i_ready = 1'b1;
                        i_data  = i_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
                    end else begin
                        d_ready = 1'b1;
                        if (split && !MISALIGN)
                            d_err = 1'b1;
                        else if (!d_we)
                            d_rdata = ld_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_sched.sv
// Randomized bench for mem_port_sched against a byte-addressed reference memory model.
module tb_mem_port_sched;
    import mem_port_sched_pkg::*;

    localparam int ADDR_W = 9;
    localparam int NWORDS = 1 << ADDR_W;
    localparam int NBYTES = 4 * NWORDS;
`ifdef MEM_PORT_SCHED_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              i_req = 1'b0;
    logic [31:0]       i_addr = '0;
    logic              i_ready;
    logic [15:0]       i_data;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [31:0]       d_addr = '0;
    logic [31:0]       d_wdata = '0;
    logic [2:0]        d_size = SZ_W;
    logic              d_se = 1'b0;
    logic              d_ready;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_wmask;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int overlap = 0;

    logic [31:0]       mem [0:NWORDS-1];
    logic [7:0]        rb  [0:NBYTES-1];
    logic              bd_we = 1'b0;
    logic [ADDR_W-1:0] bd_idx = '0;
    logic [31:0]       bd_val = '0;

    mem_port_sched #(.ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_se(d_se), .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wmask(ram_wmask),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bd_we) mem[bd_idx] <= bd_val;
        if (ram_en) begin
            ram_rdata <= mem[ram_addr];
            if (ram_we)
                for (int k = 0; k < 4; k++)
                    if (ram_wmask[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
        end
    end

    always @(negedge clock) if (i_ready && d_ready) overlap <= overlap + 1;

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] size);
        case (size)
            SZ_B:    return 1;
            SZ_H:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit splits(input logic [31:0] addr, input logic [2:0] size);
        return (int'(addr[1:0]) + nbytes(size)) > 4;
    endfunction

    function automatic int bidx(input logic [31:0] addr, input int i);
        return (int'(addr[ADDR_W+1:0]) + i) % NBYTES;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] size, input logic se);
        logic [31:0] v;
        int n;
        n = nbytes(size);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rb[bidx(addr, i)];
        if (se && n < 4 && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [15:0] ref_hw(input logic [31:0] addr);
        int b;
        b = bidx({addr[31:1], 1'b0}, 0);
        return {rb[b+1], rb[b]};
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] size);
        if (splits(addr, size) && !MIS) return;
        for (int i = 0; i < nbytes(size); i++) rb[bidx(addr, i)] = wd[8*i +: 8];
    endtask

    // ---------------- drivers ----------------
    task automatic set_word(input int idx, input logic [31:0] val);
        bd_we  = 1'b1;
        bd_idx = ADDR_W'(idx);
        bd_val = val;
        for (int k = 0; k < 4; k++) rb[4*idx+k] = val[8*k +: 8];
        @(posedge clock); #1;
        bd_we = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] addr, output logic [15:0] data, output int lat);
        @(posedge clock); #1;
        i_req  = 1'b1;
        i_addr = addr;
        lat    = -1;
        data   = 'x;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (i_ready) begin lat = c; data = i_data; break; end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        i_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] size, input logic se,
                           output logic [31:0] rd, output logic err, output int lat,
                           output int nen, output logic [ADDR_W-1:0] a0, output logic [ADDR_W-1:0] a1);
        @(posedge clock); #1;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; d_size = size; d_se = se;
        lat = -1; nen = 0; rd = 'x; err = 1'bx; a0 = '0; a1 = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (d_ready) begin lat = c; rd = d_rdata; err = d_err; break; end
            if (ram_en) begin
                if (nen == 0) a0 = ram_addr; else a1 = ram_addr;
                nen++;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        d_req = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [97:0] obs;
        for (int t = 0; t < 2; t++) begin
            i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
            i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            @(negedge clock);
            obs = {ram_en, ram_we, ram_addr, ram_wmask, ram_wdata, i_ready, i_data,
                   d_ready, d_rdata, d_err};
            n_tests++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs t=%0d got=%h want=0", t, obs);
            end
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic test_fetch();
        logic [15:0] h;
        int lat;
        set_word(0, 32'h11223344);
        do_fetch(32'h2, h, lat);
        n_tests++;
        if (lat !== 1 || h !== 16'h1122) begin
            n_fail++; $display("FAIL fetch_hi got lat=%0d data=%h want lat=1 data=1122", lat, h);
        end
        do_fetch(32'h0, h, lat);
        n_tests++;
        if (lat !== 1 || h !== 16'h3344) begin
            n_fail++; $display("FAIL fetch_lo got lat=%0d data=%h want lat=1 data=3344", lat, h);
        end
        do_fetch(32'h3, h, lat);
        n_tests++;
        if (lat !== 1 || h !== 16'h1122) begin
            n_fail++; $display("FAIL fetch_bit0 got lat=%0d data=%h want lat=1 data=1122", lat, h);
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] rd; logic err; int lat, nen; logic [ADDR_W-1:0] a0, a1;
        set_word(0, 32'h80FF0000);
        do_data(1'b0, 32'h2, 32'h0, SZ_B, 1'b1, rd, err, lat, nen, a0, a1);
        n_tests++;
        if (lat !== 1 || err !== 1'b0 || rd !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL load_byte_se got lat=%0d err=%b rd=%h want 1 0 ffffffff", lat, err, rd);
        end
        do_data(1'b0, 32'h2, 32'h0, SZ_B, 1'b0, rd, err, lat, nen, a0, a1);
        n_tests++;
        if (lat !== 1 || rd !== 32'h000000FF) begin
            n_fail++; $display("FAIL load_byte_ze got lat=%0d rd=%h want 1 000000ff", lat, rd);
        end
        do_data(1'b0, 32'h2, 32'h0, SZ_H, 1'b1, rd, err, lat, nen, a0, a1);
        n_tests++;
        if (lat !== 1 || rd !== 32'hFFFF80FF) begin
            n_fail++; $display("FAIL load_half_se got lat=%0d rd=%h want 1 ffff80ff", lat, rd);
        end
    endtask

    task automatic test_split_store();
        logic [48:0] tab [3];
        logic [48:0] obs;
        logic        saw;
`ifdef MEM_PORT_SCHED_MISALIGN_EN
        tab[0] = {1'b1, 1'b1, 9'd1, 4'b1110, 32'hBBCCDD00, 1'b0, 1'b0};
        tab[1] = {1'b1, 1'b1, 9'd2, 4'b0001, 32'h000000AA, 1'b0, 1'b0};
        tab[2] = {1'b0, 1'b0, 9'd0, 4'b0000, 32'h00000000, 1'b1, 1'b0};
`else
        tab[0] = '0;
        tab[1] = {1'b0, 1'b0, 9'd0, 4'b0000, 32'h00000000, 1'b1, 1'b1};
        tab[2] = '0;
`endif
        set_word(1, 32'h01020304);
        set_word(2, 32'h05060708);
        @(posedge clock); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h5; d_wdata = 32'hAABBCCDD; d_size = SZ_W; d_se = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            obs = {ram_en, ram_we, ram_addr, ram_wmask, ram_wdata, d_ready, d_err};
            saw = d_ready;
            n_tests++;
            if (obs !== tab[c]) begin
                n_fail++; $display("FAIL split_store_cycle%0d got=%h want=%h", c, obs, tab[c]);
            end
            @(posedge clock); #1;
            if (saw) d_req = 1'b0;
        end
        d_req = 1'b0;
        ref_store(32'h5, 32'hAABBCCDD, SZ_W);
        n_tests++;
        if (mem[1] !== ref_word(1) || mem[2] !== ref_word(2)) begin
            n_fail++;
            $display("FAIL split_store_mem got %h %h want %h %h", mem[1], mem[2], ref_word(1), ref_word(2));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd, erd; logic err, eerr; int lat, nen, elat, enen;
        logic [ADDR_W-1:0] a0, a1;
        set_word(NWORDS-1, 32'h12000000);
        set_word(0, 32'h00000034);
        eerr = !MIS;
        elat = MIS ? 2 : 1;
        enen = MIS ? 2 : 0;
        erd  = MIS ? ref_load(32'h7FF, SZ_H, 1'b0) : 32'h0;
        do_data(1'b0, 32'h7FF, 32'h0, SZ_H, 1'b0, rd, err, lat, nen, a0, a1);
        n_tests++;
        if (lat !== elat || err !== eerr || rd !== erd || nen !== enen ||
            (MIS && (a0 !== ADDR_W'(NWORDS-1) || a1 !== '0))) begin
            n_fail++;
            $display("FAIL wrap_half got lat=%0d err=%b rd=%h nen=%0d a0=%0d a1=%0d want lat=%0d err=%b rd=%h nen=%0d",
                     lat, err, rd, nen, a0, a1, elat, eerr, erd, enen);
        end
        n_tests++;
        if (MIS && erd !== 32'h00003412) begin
            n_fail++; $display("FAIL wrap_model got=%h want=00003412", erd);
        end
    endtask

    task automatic test_misalign_word();
        logic [31:0] rd, erd; logic err; int lat, nen, elat, enen;
        logic [ADDR_W-1:0] a0, a1;
        set_word(0, $urandom);
        set_word(1, $urandom);
        elat = MIS ? 2 : 1;
        enen = MIS ? 2 : 0;
        erd  = MIS ? ref_load(32'h1, SZ_W, 1'b0) : 32'h0;
        do_data(1'b0, 32'h1, 32'h0, SZ_W, 1'b0, rd, err, lat, nen, a0, a1);
        n_tests++;
        if (lat !== elat || err !== !MIS || rd !== erd || nen !== enen) begin
            n_fail++;
            $display("FAIL misalign_word got lat=%0d err=%b rd=%h nen=%0d want lat=%0d err=%b rd=%h nen=%0d",
                     lat, err, rd, nen, elat, !MIS, erd, enen);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pat, h1, h2;
        logic [31:0] drd1, drd2;
        pat = '0; h1 = '0; h2 = '0; drd1 = '0; drd2 = '0;
        @(posedge clock); #1;
        reset = 1'b0;
        i_req = 1'b1; i_addr = 32'h2;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_size = SZ_W; d_se = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            pat[2*c +: 2] = {i_ready, d_ready};
            if (c == 1) drd1 = d_rdata;
            if (c == 5) drd2 = d_rdata;
            if (c == 3) h1 = i_data;
            if (c == 7) h2 = i_data;
            if (c == 6) begin
                @(posedge clock); #1;
                i_req = 1'b0; d_req = 1'b0;
            end
        end
        n_tests++;
        if (pat !== 16'h8484) begin
            n_fail++; $display("FAIL rr_ready_pattern got=%h want=8484", pat);
        end
        n_tests++;
        if (drd1 !== ref_load(32'h10, SZ_W, 1'b0) || drd2 !== ref_load(32'h10, SZ_W, 1'b0) ||
            h1 !== ref_hw(32'h2) || h2 !== ref_hw(32'h2)) begin
            n_fail++;
            $display("FAIL rr_data got d=%h,%h i=%h,%h want d=%h i=%h", drd1, drd2, h1, h2,
                     ref_load(32'h10, SZ_W, 1'b0), ref_hw(32'h2));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] wd; logic [1:0] ctl; logic [15:0] h; int lat;
        set_word(9, 32'h11111111);
        set_word(10, 32'h22222222);
        wd = $urandom;
        @(posedge clock); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h25; d_wdata = wd; d_size = SZ_W; d_se = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        ctl = {ram_en, d_ready};
        n_tests++;
        if (ctl !== 2'b00) begin
            n_fail++; $display("FAIL reset_mid_drop got en,ready=%b want 00", ctl);
        end
        d_req = 1'b0; d_we = 1'b0;
        // only word0 of the split store landed before reset
        if (MIS) for (int i = 0; i < 3; i++) rb[bidx(32'h25, i)] = wd[8*i +: 8];
        @(posedge clock); #1;
        reset = 1'b1;
        do_fetch(32'h26, h, lat);
        n_tests++;
        if (lat !== 1 || h !== ref_hw(32'h26)) begin
            n_fail++; $display("FAIL reset_mid_idle got lat=%0d data=%h want lat=1 data=%h", lat, h, ref_hw(32'h26));
        end
        n_tests++;
        if (mem[9] !== ref_word(9) || mem[10] !== ref_word(10)) begin
            n_fail++;
            $display("FAIL reset_mid_mem got %h %h want %h %h", mem[9], mem[10], ref_word(9), ref_word(10));
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, wd, rd, erd; logic we, se, err, eerr, sp; logic [2:0] size;
        logic [15:0] h, eh; int lat, elat, nen, lo; logic [ADDR_W-1:0] a0, a1;
        for (int t = 0; t < 200; t++) begin
            addr = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                eh = ref_hw(addr);
                do_fetch(addr, h, lat);
                n_tests++;
                if (lat !== 1 || h !== eh) begin
                    n_fail++; $display("FAIL rand_fetch t=%0d addr=%h got lat=%0d data=%h want 1 %h", t, addr, lat, h, eh);
                end
            end else begin
                lo = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 63))
                                                 : int'($urandom_range(NBYTES - 64, NBYTES - 1));
                addr[ADDR_W+1:0] = lo[ADDR_W+1:0];
                we = 1'($urandom_range(0, 1));
                se = 1'($urandom_range(0, 1));
                wd = $urandom;
                case ($urandom_range(0, 2))
                    0:       size = SZ_B;
                    1:       size = SZ_H;
                    default: size = SZ_W;
                endcase
                sp   = splits(addr, size);
                eerr = sp && !MIS;
                elat = (sp && MIS) ? 2 : 1;
                erd  = (eerr || we) ? 32'h0 : ref_load(addr, size, se);
                do_data(we, addr, wd, size, se, rd, err, lat, nen, a0, a1);
                if (we) ref_store(addr, wd, size);
                n_tests++;
                if (lat !== elat || err !== eerr || rd !== erd) begin
                    n_fail++;
                    $display("FAIL rand_data t=%0d we=%b addr=%h size=%b got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h",
                             t, we, addr, size, lat, err, rd, elat, eerr, erd);
                end
            end
        end
        n_tests++;
        if (overlap !== 0) begin
            n_fail++; $display("FAIL ready_overlap got=%0d want=0", overlap);
        end
    endtask

    task automatic test_mem_image();
        int bad;
        bad = 0;
        for (int w = 0; w < NWORDS; w++) if (mem[w] !== ref_word(w)) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL mem_image got %0d differing words want 0", bad);
        end
    endtask

    initial begin
        for (int w = 0; w < NWORDS; w++) set_word(w, $urandom);
        test_reset();
        test_fetch();
        test_load_ext();
        test_split_store();
        test_wrap();
        test_misalign_word();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_mem_image();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
